// File: rtl/select_encode_seq_if.sv
// select_encode_seq_if: control, instruction and decoded-select signals between the
// control unit (master) and the select/encode stage (slave).
interface select_encode_seq_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned IDX_W   = $clog2(REG_CNT)
);
  logic               ir_load;
  logic [DATA_W-1:0]  instruction;
  logic               Gra;
  logic               Grb;
  logic               Grc;
  logic               Rin;
  logic               Rout;
  logic               BAout;
  logic               seq_start;
  logic [2:0]         seq_mask;
  logic               seq_busy;
  logic               seq_done;
  logic [REG_CNT-1:0] register_enable;
  logic [REG_CNT-1:0] register_select;
  logic               ba_zero;
  logic [IDX_W-1:0]   sel_idx;
  logic [DATA_W-1:0]  C_sign_ext_Data;

  modport master (
    output ir_load, instruction, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_mask,
    input  seq_busy, seq_done, register_enable, register_select, ba_zero, sel_idx,
           C_sign_ext_Data
  );

  modport slave (
    input  ir_load, instruction, Gra, Grb, Grc, Rin, Rout, BAout, seq_start, seq_mask,
    output seq_busy, seq_done, register_enable, register_select, ba_zero, sel_idx,
           C_sign_ext_Data
  );
endinterface

// File: rtl/select_encode_seq.sv
// select_encode_seq: registered IR, register-field select and one-hot encode stage with
// sign-extended constant C. Define SEL_ENC_SEQ_EN to compile in the operand-fetch
// sequencer that walks the Ra/Rb/Rc fields onto the bus by itself.
module select_encode_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned IDX_W   = $clog2(REG_CNT),
  parameter int unsigned RA_LSB  = 23,
  parameter int unsigned RB_LSB  = 19,
  parameter int unsigned RC_LSB  = 15,
  parameter int unsigned C_W     = 19
) (
  input logic                clk,
  input logic                clr,
  select_encode_seq_if.slave bus
);

  logic [DATA_W-1:0]  ir_q, ir_d;
  logic [IDX_W-1:0]   idx_q, idx_d, dir_idx;
  logic [REG_CNT-1:0] en_q, en_d;
  logic [REG_CNT-1:0] sel_q, sel_d;
  logic               baz_q, baz_d;

  function automatic logic [REG_CNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REG_CNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef SEL_ENC_SEQ_EN
  typedef enum logic [2:0] {StIdle, StFa, StFb, StFc, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rb_snap_q, rb_snap_d;
  logic [IDX_W-1:0] rc_snap_q, rc_snap_d;
  logic [1:0]       mask_q, mask_d;  // remaining Rb/Rc requests of the running sequence
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`endif

  // Next state: IR capture, direct-mode decode, then sequencer override when active.
  always_comb begin
    ir_d = bus.ir_load ? bus.instruction : ir_q;

    if (bus.Gra)      dir_idx = ir_q[RA_LSB +: IDX_W];
    else if (bus.Grb) dir_idx = ir_q[RB_LSB +: IDX_W];
    else if (bus.Grc) dir_idx = ir_q[RC_LSB +: IDX_W];
    else              dir_idx = idx_q;

    idx_d = dir_idx;
    en_d  = onehot(dir_idx) & {REG_CNT{bus.Rin}};
    sel_d = onehot(dir_idx) & {REG_CNT{bus.Rout | bus.BAout}};
    baz_d = bus.BAout & (dir_idx == '0);

`ifdef SEL_ENC_SEQ_EN
    state_d   = state_q;
    rb_snap_d = rb_snap_q;
    rc_snap_d = rc_snap_q;
    mask_d    = mask_q;

    unique case (state_q)
      // DONE behaves as IDLE for the next edge so a new start is accepted back-to-back.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.seq_start) begin
          rb_snap_d = ir_q[RB_LSB +: IDX_W];
          rc_snap_d = ir_q[RC_LSB +: IDX_W];
          mask_d    = bus.seq_mask[2:1];
          if (bus.seq_mask[0])      state_d = StFa;
          else if (bus.seq_mask[1]) state_d = StFb;
          else if (bus.seq_mask[2]) state_d = StFc;
          else                      state_d = StDone;
        end
      end
      StFa:    state_d = mask_q[0] ? StFb : (mask_q[1] ? StFc : StDone);
      StFb:    state_d = mask_q[1] ? StFc : StDone;
      StFc:    state_d = StDone;
      default: state_d = StIdle;
    endcase

    // A busy next state owns the outputs; direct requests are dropped.
    if (state_d != StIdle) begin
      idx_d = idx_q;
      en_d  = '0;
      sel_d = '0;
      baz_d = 1'b0;
      case (state_d)
        StFa:    idx_d = ir_q[RA_LSB +: IDX_W];  // FA is only entered from start
        StFb:    idx_d = rb_snap_d;
        StFc:    idx_d = rc_snap_d;
        default: ;
      endcase
      if (state_d != StDone) sel_d = onehot(idx_d);
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
`endif
  end

  // Datapath and decoded-output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir_q  <= '0;
      idx_q <= '0;
      en_q  <= '0;
      sel_q <= '0;
      baz_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      idx_q <= idx_d;
      en_q  <= en_d;
      sel_q <= sel_d;
      baz_q <= baz_d;
    end
  end

`ifdef SEL_ENC_SEQ_EN
  // Sequencer state, field snapshot and status flags.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      rb_snap_q <= '0;
      rc_snap_q <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rb_snap_q <= rb_snap_d;
      rc_snap_q <= rc_snap_d;
      mask_q    <= mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.seq_busy = busy_q;
  assign bus.seq_done = done_q;
`else
  logic unused_seq;
  assign unused_seq   = ^{bus.seq_start, bus.seq_mask};
  assign bus.seq_busy = 1'b0;
  assign bus.seq_done = 1'b0;
`endif

  // Only the field and constant bits of IR are decoded here.
  logic unused_ir;
  assign unused_ir = ^ir_q;

  assign bus.register_enable = en_q;
  assign bus.register_select = sel_q;
  assign bus.ba_zero         = baz_q;
  assign bus.sel_idx         = idx_q;
  assign bus.C_sign_ext_Data = {{(DATA_W - C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

endmodule

// File: tb/tb_select_encode_seq.sv
// tb_select_encode_seq: directed and randomized checks of select_encode_seq against a
// field/one-hot reference model. Sequencer scenarios follow the SEL_ENC_SEQ_EN build.
module tb_select_encode_seq;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  select_encode_seq_if #(.DATA_W(32), .REG_CNT(16)) bus0 ();
  select_encode_seq_if #(.DATA_W(32), .REG_CNT(32)) bus1 ();

  select_encode_seq #(.REG_CNT(16)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus0)
  );

  select_encode_seq #(.REG_CNT(32)) u_dut32 (
    .clk (clk),
    .clr (clr),
    .bus (bus1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: IR contents and last decoded index (16-register build).
  logic [31:0] m_ir;
  int          m_idx;

  function automatic logic [31:0] make_ir(int ra_v, int rb_v, int rc_v, int c_v);
    return 32'((ra_v << 23) | (rb_v << 19) | (rc_v << 15) | c_v);
  endfunction

  function automatic int ra_of(logic [31:0] w); return int'((w >> 23) & 32'hF); endfunction
  function automatic int rb_of(logic [31:0] w); return int'((w >> 19) & 32'hF); endfunction
  function automatic int rc_of(logic [31:0] w); return int'((w >> 15) & 32'hF); endfunction

  function automatic logic [15:0] oh16(int i);
    return 16'(1 << i);
  endfunction

  function automatic logic [31:0] sext_c(logic [31:0] w);
    int c;
    c = int'(w & 32'h7FFFF);
    if (c >= 32'h40000) c = c - 32'h80000;
    return 32'(c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.ir_load = 1'b0; bus0.instruction = '0; bus0.Gra = 1'b0; bus0.Grb = 1'b0;
    bus0.Grc = 1'b0; bus0.Rin = 1'b0; bus0.Rout = 1'b0; bus0.BAout = 1'b0;
    bus0.seq_start = 1'b0; bus0.seq_mask = '0;
    bus1.ir_load = 1'b0; bus1.instruction = '0; bus1.Gra = 1'b0; bus1.Grb = 1'b0;
    bus1.Grc = 1'b0; bus1.Rin = 1'b0; bus1.Rout = 1'b0; bus1.BAout = 1'b0;
    bus1.seq_start = 1'b0; bus1.seq_mask = '0;
  endtask

  task automatic load_ir(input logic [31:0] w);
    clear_inputs();
    bus0.ir_load = 1'b1;
    bus0.instruction = w;
    m_ir = w;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus0.register_enable, bus0.register_select, bus0.ba_zero, bus0.sel_idx} !== '0)
      begin
      errors++;
      $display("FAIL reset_select: got en=%h sel=%h baz=%b idx=%0d expected all 0",
               bus0.register_enable, bus0.register_select, bus0.ba_zero, bus0.sel_idx);
    end
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.C_sign_ext_Data} !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b C=%h expected 0/0/00000000",
               bus0.seq_busy, bus0.seq_done, bus0.C_sign_ext_Data);
    end
    clr = 1'b0;
    m_ir = '0;
    m_idx = 0;
    step();
  endtask

  task automatic test_direct();
    load_ir(32'h0B9A_8000);
    bus0.Gra = 1'b1; bus0.Rin = 1'b1;
    m_idx = 7;
    step();
    clear_inputs();
    checks++;
    if ({bus0.register_enable, bus0.register_select, bus0.sel_idx} !==
        {16'h0080, 16'h0000, 4'd7}) begin
      errors++;
      $display("FAIL direct_gra_rin: got en=%h sel=%h idx=%0d expected 0080/0000/7",
               bus0.register_enable, bus0.register_select, bus0.sel_idx);
    end
  endtask

  task automatic test_priority_hold();
    bus0.Gra = 1'b1; bus0.Grb = 1'b1; bus0.Rout = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus0.register_enable, bus0.register_select} !== {16'h0000, 16'h0080}) begin
      errors++;
      $display("FAIL priority_gra: got en=%h sel=%h expected 0000/0080",
               bus0.register_enable, bus0.register_select);
    end
    bus0.Rout = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus0.register_select, bus0.sel_idx} !== {16'h0080, 4'd7}) begin
      errors++;
      $display("FAIL hold_idx: got sel=%h idx=%0d expected 0080/7",
               bus0.register_select, bus0.sel_idx);
    end
  endtask

  task automatic test_ba_zero();
    load_ir(make_ir(2, 0, 6, 0));
    bus0.Grb = 1'b1; bus0.BAout = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus0.register_select, bus0.ba_zero} !== {16'h0001, 1'b1}) begin
      errors++;
      $display("FAIL ba_zero_r0: got sel=%h baz=%b expected 0001/1",
               bus0.register_select, bus0.ba_zero);
    end
    load_ir(make_ir(2, 4, 6, 0));
    bus0.Grb = 1'b1; bus0.BAout = 1'b1;
    step();
    clear_inputs();
    m_idx = 4;
    checks++;
    if ({bus0.register_select, bus0.ba_zero} !== {16'h0010, 1'b0}) begin
      errors++;
      $display("FAIL ba_zero_r4: got sel=%h baz=%b expected 0010/0",
               bus0.register_select, bus0.ba_zero);
    end
  endtask

  task automatic test_sign_ext();
    load_ir(32'h0004_0000);
    checks++;
    if (bus0.C_sign_ext_Data !== 32'hFFFC_0000) begin
      errors++;
      $display("FAIL sext_neg: got %h expected FFFC0000", bus0.C_sign_ext_Data);
    end
    load_ir(32'hFFF3_FFFF);
    checks++;
    if (bus0.C_sign_ext_Data !== 32'h0003_FFFF) begin
      errors++;
      $display("FAIL sext_pos: got %h expected 0003FFFF", bus0.C_sign_ext_Data);
    end
  endtask

  task automatic test_random_direct();
    logic [15:0] e_en, e_sel;
    logic        e_baz;
    for (int i = 0; i < 60; i++) begin
      clear_inputs();
      bus0.ir_load     = 1'($urandom_range(0, 1));
      bus0.instruction = $urandom;
      bus0.Gra   = ($urandom_range(0, 3) == 0);
      bus0.Grb   = ($urandom_range(0, 3) == 0);
      bus0.Grc   = ($urandom_range(0, 2) == 0);
      bus0.Rin   = 1'($urandom_range(0, 1));
      bus0.Rout  = 1'($urandom_range(0, 1));
      bus0.BAout = ($urandom_range(0, 3) == 0);
      if (bus0.Gra)      m_idx = ra_of(m_ir);
      else if (bus0.Grb) m_idx = rb_of(m_ir);
      else if (bus0.Grc) m_idx = rc_of(m_ir);
      e_en  = bus0.Rin ? oh16(m_idx) : 16'h0;
      e_sel = (bus0.Rout || bus0.BAout) ? oh16(m_idx) : 16'h0;
      e_baz = bus0.BAout && (m_idx == 0);
      if (bus0.ir_load) m_ir = bus0.instruction;
      step();
      checks++;
      if ({bus0.register_enable, bus0.register_select, bus0.ba_zero, bus0.sel_idx} !==
          {e_en, e_sel, e_baz, 4'(m_idx)}) begin
        errors++;
        $display("FAIL rand_direct[%0d]: got en=%h sel=%h baz=%b idx=%0d expected %h/%h/%b/%0d",
                 i, bus0.register_enable, bus0.register_select, bus0.ba_zero, bus0.sel_idx,
                 e_en, e_sel, e_baz, m_idx);
      end
      checks++;
      if (bus0.C_sign_ext_Data !== sext_c(m_ir)) begin
        errors++;
        $display("FAIL rand_sext[%0d]: got %h expected %h", i, bus0.C_sign_ext_Data,
                 sext_c(m_ir));
      end
    end
    clear_inputs();
  endtask

  task automatic test_regcnt32();
    clear_inputs();
    bus1.ir_load = 1'b1;
    bus1.instruction = 32'(31) << 23;
    step();
    clear_inputs();
    bus1.Gra = 1'b1; bus1.Rin = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus1.register_enable, bus1.sel_idx} !== {32'h8000_0000, 5'd31}) begin
      errors++;
      $display("FAIL regcnt32_r31: got en=%h idx=%0d expected 80000000/31",
               bus1.register_enable, bus1.sel_idx);
    end
  endtask

`ifdef SEL_ENC_SEQ_EN
  // Random direct-mode and IR traffic; all of it must be ignored except the IR load.
  task automatic junk();
    bus0.Gra   = 1'($urandom_range(0, 1));
    bus0.Grb   = 1'($urandom_range(0, 1));
    bus0.Grc   = 1'($urandom_range(0, 1));
    bus0.Rin   = 1'($urandom_range(0, 1));
    bus0.Rout  = 1'($urandom_range(0, 1));
    bus0.BAout = 1'($urandom_range(0, 1));
    bus0.ir_load     = 1'($urandom_range(0, 1));
    bus0.instruction = $urandom;
    if (bus0.ir_load) m_ir = bus0.instruction;
  endtask

  task automatic run_seq(input logic [2:0] mask);
    logic [15:0] expq[$];
    if (mask[0]) expq.push_back(oh16(ra_of(m_ir)));
    if (mask[1]) expq.push_back(oh16(rb_of(m_ir)));
    if (mask[2]) expq.push_back(oh16(rc_of(m_ir)));
    junk();
    bus0.seq_start = 1'b1;
    bus0.seq_mask  = mask;
    step();
    foreach (expq[i]) begin
      checks++;
      if ({bus0.seq_busy, bus0.seq_done, bus0.ba_zero, bus0.register_enable,
           bus0.register_select} !== {1'b1, 1'b0, 1'b0, 16'h0, expq[i]}) begin
        errors++;
        $display("FAIL seq_field m=%b #%0d: got busy=%b done=%b baz=%b en=%h sel=%h expected 1/0/0/0000/%h",
                 mask, i, bus0.seq_busy, bus0.seq_done, bus0.ba_zero,
                 bus0.register_enable, bus0.register_select, expq[i]);
      end
      junk();
      bus0.seq_start = 1'($urandom_range(0, 1));
      bus0.seq_mask  = 3'($urandom_range(0, 7));
      step();
    end
    clear_inputs();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select} !==
        {1'b1, 1'b1, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL seq_done m=%b: got busy=%b done=%b en=%h sel=%h expected 1/1/0000/0000",
               mask, bus0.seq_busy, bus0.seq_done, bus0.register_enable,
               bus0.register_select);
    end
  endtask

  task automatic check_idle(input string name);
    clear_inputs();
    step();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select} !== '0)
      begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b en=%h sel=%h expected all 0", name,
               bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select);
    end
  endtask

  task automatic resync();
    clear_inputs();
    bus0.Gra = 1'b1; bus0.Rout = 1'b1;
    m_idx = ra_of(m_ir);
    step();
    clear_inputs();
    checks++;
    if ({bus0.register_select, bus0.sel_idx} !== {oh16(m_idx), 4'(m_idx)}) begin
      errors++;
      $display("FAIL resync: got sel=%h idx=%0d expected %h/%0d",
               bus0.register_select, bus0.sel_idx, oh16(m_idx), m_idx);
    end
  endtask

  task automatic test_seq_basic();
    load_ir(32'h0B9A_8000);
    // Simultaneous direct request must lose to the start.
    bus0.seq_start = 1'b1; bus0.seq_mask = 3'b101; bus0.Grc = 1'b1; bus0.Rin = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select} !==
        {1'b1, 1'b0, 16'h0, 16'h0080}) begin
      errors++;
      $display("FAIL seq101_fa: got busy=%b done=%b en=%h sel=%h expected 1/0/0000/0080",
               bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select);
    end
    step();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select} !==
        {1'b1, 1'b0, 16'h0, 16'h0020}) begin
      errors++;
      $display("FAIL seq101_fc: got busy=%b done=%b en=%h sel=%h expected 1/0/0000/0020",
               bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select);
    end
    step();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_select} !== {1'b1, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL seq101_done: got busy=%b done=%b sel=%h expected 1/1/0000",
               bus0.seq_busy, bus0.seq_done, bus0.register_select);
    end
    check_idle("seq101_idle");
    bus0.seq_start = 1'b1; bus0.seq_mask = 3'b000;
    step();
    clear_inputs();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_select} !== {1'b1, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL seq000_done: got busy=%b done=%b sel=%h expected 1/1/0000",
               bus0.seq_busy, bus0.seq_done, bus0.register_select);
    end
    check_idle("seq000_idle");
    resync();
  endtask

  task automatic test_seq_interlock();
    load_ir(32'h0B9A_8000);
    bus0.seq_start = 1'b1; bus0.seq_mask = 3'b111;
    step();
    clear_inputs();
    bus0.ir_load = 1'b1; bus0.instruction = make_ir(1, 2, 9, 0);
    bus0.Gra = 1'b1; bus0.Rin = 1'b1; bus0.seq_start = 1'b1;
    m_ir = make_ir(1, 2, 9, 0);
    step();
    clear_inputs();
    checks++;
    if ({bus0.register_enable, bus0.register_select} !== {16'h0, 16'h0008}) begin
      errors++;
      $display("FAIL interlock_fb: got en=%h sel=%h expected 0000/0008",
               bus0.register_enable, bus0.register_select);
    end
    step();
    checks++;
    if ({bus0.register_enable, bus0.register_select} !== {16'h0, 16'h0020}) begin
      errors++;
      $display("FAIL interlock_fc: got en=%h sel=%h expected 0000/0020",
               bus0.register_enable, bus0.register_select);
    end
    step();
    check_idle("interlock_idle");
    resync();
  endtask

  task automatic test_seq_reset();
    load_ir(32'h0B9A_8000);
    bus0.seq_start = 1'b1; bus0.seq_mask = 3'b111;
    step();
    clear_inputs();
    step();
    checks++;
    if (bus0.register_select !== 16'h0008) begin
      errors++;
      $display("FAIL reset_pre_fb: got sel=%h expected 0008", bus0.register_select);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_enable, bus0.register_select,
         bus0.ba_zero, bus0.sel_idx, bus0.C_sign_ext_Data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_seq: got busy=%b done=%b sel=%h idx=%0d C=%h expected all 0",
               bus0.seq_busy, bus0.seq_done, bus0.register_select, bus0.sel_idx,
               bus0.C_sign_ext_Data);
    end
    step();
    clr = 1'b0;
    m_ir = '0;
    m_idx = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus0.seq_busy, bus0.seq_done} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_done[%0d]: got busy=%b done=%b expected 0/0", i,
                 bus0.seq_busy, bus0.seq_done);
      end
    end
  endtask

  task automatic test_seq_random();
    for (int i = 0; i < 24; i++) begin
      run_seq(3'($urandom_range(0, 7)));
      // Otherwise the next start lands on the DONE cycle edge (back-to-back).
      if (i == 23 || $urandom_range(0, 1) == 0) begin
        check_idle("rand_seq_idle");
        resync();
      end
    end
  endtask
`else
  task automatic test_seq_disabled();
    load_ir(32'h0B9A_8000);
    bus0.seq_start = 1'b1; bus0.seq_mask = 3'b111;
    step();
    clear_inputs();
    checks++;
    if ({bus0.seq_busy, bus0.seq_done, bus0.register_select, bus0.sel_idx} !==
        {1'b0, 1'b0, 16'h0, 4'(m_idx)}) begin
      errors++;
      $display("FAIL nosq_start: got busy=%b done=%b sel=%h idx=%0d expected 0/0/0000/%0d",
               bus0.seq_busy, bus0.seq_done, bus0.register_select, bus0.sel_idx, m_idx);
    end
    bus0.seq_start = 1'b1; bus0.seq_mask = 3'b001; bus0.Gra = 1'b1; bus0.Rin = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus0.seq_busy, bus0.register_enable} !== {1'b0, 16'h0080}) begin
      errors++;
      $display("FAIL nosq_direct: got busy=%b en=%h expected 0/0080",
               bus0.seq_busy, bus0.register_enable);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus0.seq_busy, bus0.seq_done} !== 2'b00) begin
        errors++;
        $display("FAIL nosq_idle[%0d]: got busy=%b done=%b expected 0/0", i,
                 bus0.seq_busy, bus0.seq_done);
      end
    end
  endtask
`endif

  initial begin
    clr = 1'b1;
    clear_inputs();
    test_reset();
    test_direct();
    test_priority_hold();
    test_ba_zero();
    test_sign_ext();
    test_random_direct();
    test_regcnt32();
`ifdef SEL_ENC_SEQ_EN
    test_seq_basic();
    test_seq_interlock();
    test_seq_reset();
    test_seq_random();
`else
    test_seq_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
